// File: rtl/c_seq_pkg.sv
// c_seq_pkg -- shared constants, state type and LFSR step helper for the
// NR Gold-sequence generator (c_seq_gen_ff) and its LFSR advance block.
package c_seq_pkg;

   localparam int NC       = 1600;
   localparam int LFSR_LEN = 31;
   localparam int RW       = 17;   // holds NC + max 16-bit skip

   localparam logic [LFSR_LEN-1:0] X1_INIT = 31'd1;
   // Tap masks over state s[i] = x(n+i):
   //   x1(n+31) = x1(n+3) ^ x1(n)
   //   x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
   localparam logic [LFSR_LEN-1:0] X1_TAPS = 31'h0000_0009;
   localparam logic [LFSR_LEN-1:0] X2_TAPS = 31'h0000_000F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WARM = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // One Fibonacci step: the oldest bit s[0] drops out, the new bit enters at the top.
   function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s,
                                                      input logic [LFSR_LEN-1:0] taps);
      return {^(s & taps), s[LFSR_LEN-1:1]};
   endfunction

endpackage

// File: rtl/c_seq_gen_ff_adv.sv
// lfsr31_adv -- combinational K-bit advance of one 31-bit Fibonacci LFSR.
// Ports:
//   s_i  31  current state, s_i[i] = x(n+i)
//   s_o  31  state after K steps, s_o[i] = x(n+K+i)
// Parameters: K (steps), TAPS (feedback tap mask from c_seq_pkg).
module lfsr31_adv
   import c_seq_pkg::*;
#(
   parameter int                  K    = 8,
   parameter logic [LFSR_LEN-1:0] TAPS = X1_TAPS
) (
   input  logic [LFSR_LEN-1:0] s_i,
   output logic [LFSR_LEN-1:0] s_o
);

   always_comb begin
      s_o = s_i;
      for (int k = 0; k < K; k++) s_o = lfsr_step(s_o, TAPS);
   end

endmodule

// File: rtl/c_seq_gen_ff.sv
// c_seq_gen_ff -- NR pseudo-random (Gold) sequence generator with fast-forward.
// Skips Nc=1600 (+ optional i_skip) bits FF_STEP bits per cycle, then streams
// NGENBIT bits per word with valid/ready handshake.
// Ports:
//   clk, rst (async active-low)
//   i_load   start / restart, samples i_init, i_skip, i_len
//   i_init   31-bit c_init seed for x2
//   i_skip   extra offset in bits (multiple of NGENBIT; low bits dropped)
//   i_len    words to emit, 0 = unbounded
//   i_ready  consumer accepts o_seq
//   o_seq    NGENBIT bits, earliest bit in MSB
//   o_valid, o_last, o_busy
// Build option: define C_SEQ_GEN_FF_SKIP_EN to honour i_skip; otherwise it is ignored.
module c_seq_gen_ff
   import c_seq_pkg::*;
#(
   parameter int NGENBIT = 8,
   parameter int FF_STEP = 64,
   parameter int LENW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [30:0]         i_init,
   input  logic [15:0]         i_skip,
   input  logic [LENW-1:0]     i_len,
   input  logic                i_ready,
   output logic [NGENBIT-1:0]  o_seq,
   output logic                o_valid,
   output logic                o_last,
   output logic                o_busy
);

   state_t              state_q, state_d;
   logic [LFSR_LEN-1:0] x1_q, x1_d, x2_q, x2_d;
   logic [LFSR_LEN-1:0] x1_ff, x2_ff, x1_w, x2_w;
   logic [RW-1:0]       r_q, r_d;       // bits still to skip
   logic [LENW-1:0]     rem_q, rem_d;   // words left in a bounded run
   logic                bnd_q, bnd_d;   // run is bounded (i_len != 0)
   logic [15:0]         skip_eff;
   logic [NGENBIT-1:0]  word;
   logic [LFSR_LEN-1:0] t1, t2;

`ifdef C_SEQ_GEN_FF_SKIP_EN
   assign skip_eff = i_skip & ~16'(NGENBIT - 1);
`else
   logic skip_unused;
   assign skip_unused = ^i_skip;
   assign skip_eff    = '0;
`endif

   lfsr31_adv #(.K(FF_STEP), .TAPS(X1_TAPS)) u_x1_ff (.s_i(x1_q), .s_o(x1_ff));
   lfsr31_adv #(.K(FF_STEP), .TAPS(X2_TAPS)) u_x2_ff (.s_i(x2_q), .s_o(x2_ff));
   lfsr31_adv #(.K(NGENBIT), .TAPS(X1_TAPS)) u_x1_w  (.s_i(x1_q), .s_o(x1_w));
   lfsr31_adv #(.K(NGENBIT), .TAPS(X2_TAPS)) u_x2_w  (.s_i(x2_q), .s_o(x2_w));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         x1_q    <= '0;
         x2_q    <= '0;
         r_q     <= '0;
         rem_q   <= '0;
         bnd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         r_q     <= r_d;
         rem_q   <= rem_d;
         bnd_q   <= bnd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      r_d     = r_q;
      rem_d   = rem_q;
      bnd_d   = bnd_q;
      // A load wins in every state, including over a same-cycle transfer.
      if (i_load) begin
         state_d = ST_WARM;
         x1_d    = X1_INIT;
         x2_d    = i_init;
         r_d     = RW'(NC) + RW'(skip_eff);
         rem_d   = i_len;
         bnd_d   = |i_len;
      end else begin
         case (state_q)
            ST_WARM: begin
               if (r_q == '0) begin
                  state_d = ST_RUN;
               end else if (r_q >= RW'(FF_STEP)) begin
                  x1_d = x1_ff;
                  x2_d = x2_ff;
                  r_d  = r_q - RW'(FF_STEP);
               end else begin
                  x1_d = x1_w;
                  x2_d = x2_w;
                  r_d  = r_q - RW'(NGENBIT);
               end
            end
            ST_RUN: begin
               if (i_ready) begin
                  x1_d = x1_w;
                  x2_d = x2_w;
                  if (bnd_q) begin
                     rem_d = rem_q - LENW'(1);
                     if (rem_q == LENW'(1)) state_d = ST_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Word = c(n..n+NGENBIT-1) read from the registered state; stepping a copy
   // covers NGENBIT=32, where the last bit lies just beyond the 31-bit window.
   always_comb begin
      t1   = x1_q;
      t2   = x2_q;
      word = '0;
      for (int k = 0; k < NGENBIT; k++) begin
         word[NGENBIT-1-k] = t1[0] ^ t2[0];
         t1 = lfsr_step(t1, X1_TAPS);
         t2 = lfsr_step(t2, X2_TAPS);
      end
   end

   assign o_valid = (state_q == ST_RUN);
   assign o_busy  = (state_q != ST_IDLE);
   assign o_last  = o_valid && bnd_q && (rem_q == LENW'(1));
   assign o_seq   = o_valid ? word : '0;

endmodule

// File: tb/tb_c_seq_gen_ff.sv
// tb_c_seq_gen_ff -- drives two generators (NGENBIT=8 and NGENBIT=1, both
// FF_STEP=64) with shared directed stimulus and compares every cycle against
// a model built from the x1/x2 recurrences and the latency formula.
module tb_c_seq_gen_ff;

   logic        clk, rst, i_load, i_ready;
   logic [30:0] i_init;
   logic [15:0] i_skip, i_len;
   logic [7:0]  seq8;
   logic [0:0]  seq1;
   logic        v8, l8, b8, v1, l1, b1;

   int checks = 0;
   int errors = 0;

   c_seq_gen_ff #(.NGENBIT(8), .FF_STEP(64), .LENW(16)) dut8 (
      .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init), .i_skip(i_skip),
      .i_len(i_len), .i_ready(i_ready), .o_seq(seq8), .o_valid(v8), .o_last(l8), .o_busy(b8));

   c_seq_gen_ff #(.NGENBIT(1), .FF_STEP(64), .LENW(16)) dut1 (
      .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init), .i_skip(i_skip),
      .i_len(i_len), .i_ready(i_ready), .o_seq(seq1), .o_valid(v1), .o_last(l1), .o_busy(b1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   localparam int CN = 4096;
   bit cs [2][CN];          // c(n) for the current seed of each instance
   bit px1 [0:5727];
   bit px2 [0:5727];
   int ph [2];              // 0 idle, 1 warm, 2 run
   int cd [2];              // cycles until RUN
   int jj [2];              // index of presented word
   int ln [2];
   int sk [2];

   function automatic int ngof(input int m);
      return (m == 0) ? 8 : 1;
   endfunction

   function automatic int effskip(input int s, input int ng);
`ifdef C_SEQ_GEN_FF_SKIP_EN
      return (s / ng) * ng;
`else
      return 0 * s * ng;
`endif
   endfunction

   function automatic int wcyc(input int s, input int ng);
      return (1600 + s) / 64 + ((1600 + s) % 64) / ng;
   endfunction

   task automatic gen(input int m, input logic [30:0] init);
      bit x1 [0:5727];
      bit x2 [0:5727];
      for (int i = 0; i < 31; i++) begin
         x1[i] = (i == 0);
         x2[i] = init[i];
      end
      for (int n = 0; n + 31 < 5728; n++) begin
         x1[n+31] = x1[n+3] ^ x1[n];
         x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
      end
      for (int n = 0; n < CN; n++) cs[m][n] <= x1[n+1600] ^ x2[n+1600];
      for (int n = 0; n < 5728; n++) begin
         px1[n] <= x1[n];
         px2[n] <= x2[n];
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int m = 0; m < 2; m++) begin
            ph[m] <= 0; cd[m] <= 0; jj[m] <= 0; ln[m] <= 0; sk[m] <= 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (i_load) begin
               ph[m] <= 1;
               sk[m] <= effskip(int'(i_skip), ngof(m));
               cd[m] <= wcyc(effskip(int'(i_skip), ngof(m)), ngof(m)) + 1;
               jj[m] <= 0;
               ln[m] <= int'(i_len);
               gen(m, i_init);
            end else if (ph[m] == 1) begin
               cd[m] <= cd[m] - 1;
               if (cd[m] == 1) ph[m] <= 2;
            end else if (ph[m] == 2 && i_ready) begin
               jj[m] <= jj[m] + 1;
               if (ln[m] != 0 && jj[m] + 1 == ln[m]) ph[m] <= 0;
            end
         end
      end
   end

   function automatic logic [7:0] exp_seq(input int m);
      logic [7:0] w;
      int ng, idx;
      w  = '0;
      ng = ngof(m);
      if (ph[m] == 2)
         for (int b = 0; b < ng; b++) begin
            idx = sk[m] + jj[m] * ng + b;
            w[ng-1-b] = (idx < CN) ? cs[m][idx] : 1'b0;
         end
      return w;
   endfunction

   // ---------------- checking ----------------
   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all();
      int ev, el, eb;
      for (int m = 0; m < 2; m++) begin
         ev = (ph[m] == 2);
         el = ev && ln[m] != 0 && jj[m] == ln[m] - 1;
         eb = (ph[m] != 0);
         if (m == 0) begin
            cmp("n8 o_seq",   {56'd0, seq8}, {56'd0, exp_seq(0)});
            cmp("n8 o_valid", {63'd0, v8}, 64'(ev));
            cmp("n8 o_last",  {63'd0, l8}, 64'(el));
            cmp("n8 o_busy",  {63'd0, b8}, 64'(eb));
         end else begin
            cmp("n1 o_seq",   {63'd0, seq1}, {56'd0, exp_seq(1)});
            cmp("n1 o_valid", {63'd0, v1}, 64'(ev));
            cmp("n1 o_last",  {63'd0, l1}, 64'(el));
            cmp("n1 o_busy",  {63'd0, b1}, 64'(eb));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic load(input logic [30:0] init, input logic [15:0] skip, input logic [15:0] len);
      @(negedge clk);
      i_load = 1'b1; i_init = init; i_skip = skip; i_len = len;
      @(negedge clk);
      i_load = 1'b0;
   endtask

   // mode 0: ready high, 1: ready pattern 1-0-0-1, 2: ready high, fixed length (no idle exit)
   task automatic run(input int mode, input int maxc, output int lat8, output int lat1);
      logic [3:0] pat;
      int n;
      pat = 4'b1001;
      n = 0; lat8 = -1; lat1 = -1;
      while (n < maxc) begin
         if (lat8 < 0 && v8) lat8 = n;
         if (lat1 < 0 && v1) lat1 = n;
         if (mode != 2 && n > 0 && !b8 && !b1) break;
         i_ready = (mode == 1) ? pat[n % 4] : 1'b1;
         @(negedge clk);
         n++;
      end
      if (mode != 2) cmp("run completes", {62'd0, b8, b1}, 64'd0);
      i_ready = 1'b1;
   endtask

   function automatic int lat_exp(input int s, input int ng);
      return wcyc(effskip(s, ng), ng) + 1;
   endfunction

   int la8, la1;
   int skl;

   initial begin
      rst = 1'b1; i_load = 1'b0; i_ready = 1'b1; i_init = '0; i_skip = '0; i_len = '0;
      #1 rst = 1'b0;
      #2;
      cmp("reset o_valid", {62'd0, v8, v1}, 64'd0);
      cmp("reset o_busy",  {62'd0, b8, b1}, 64'd0);
      cmp("reset o_seq",   {55'd0, seq8, seq1}, 64'd0);
      fork
         forever begin
            @(negedge clk);
            chk_all();
         end
      join_none
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 1: seed 512, skip 336, 14 words
      load(31'd512, 16'd336, 16'd14);
      // recurrence pins for x1 (seed 1) and x2 (seed 512)
      cmp("pin x1(31)", 64'(px1[31]), 64'd1);
      cmp("pin x1(34)", 64'(px1[34]), 64'd0);
      cmp("pin x1(62)", 64'(px1[62]), 64'd1);
      cmp("pin x2(31)", 64'(px2[31]), 64'd0);
      cmp("pin x2(40)", 64'(px2[40]), 64'd1);
      cmp("pin x2(71)", 64'(px2[71]), 64'd1);
      run(0, 400, la8, la1);
`ifdef C_SEQ_GEN_FF_SKIP_EN
      skl = 33;
`else
      skl = 26;
`endif
      cmp("latency n8 skip336", 64'(la8), 64'(skl));
      cmp("latency n8 formula", 64'(la8), 64'(lat_exp(336, 8)));

      // 2: seed 100, skip 224, 112 words
      load(31'd100, 16'd224, 16'd112);
      run(0, 600, la8, la1);
`ifdef C_SEQ_GEN_FF_SKIP_EN
      skl = 61;
`else
      skl = 26;
`endif
      cmp("latency n1 skip224", 64'(la1), 64'(skl));

      // 3: skip 0, stalls
      load(31'd512, 16'd0, 16'd14);
      run(1, 400, la8, la1);
      cmp("latency n8 skip0", 64'(la8), 64'd26);
      cmp("latency n1 skip0", 64'(la1), 64'd26);

      // 4: unbounded run, then abort with a new seed
      load(31'd512, 16'd0, 16'd0);
      run(2, 60, la8, la1);
      cmp("latency unbounded", 64'(la8), 64'd26);
      load(31'd100, 16'd0, 16'd20);
      cmp("abort drops valid", {62'd0, v8, v1}, 64'd0);
      run(0, 400, la8, la1);
      cmp("latency after abort", 64'(la8), 64'd26);

      // 5: reset mid-warm, then repeat run 1
      load(31'd512, 16'd336, 16'd14);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      cmp("midrun reset valid/last", {60'd0, v8, l8, v1, l1}, 64'd0);
      cmp("midrun reset busy",       {62'd0, b8, b1}, 64'd0);
      cmp("midrun reset seq",        {55'd0, seq8, seq1}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      load(31'd512, 16'd336, 16'd14);
      run(0, 400, la8, la1);
      cmp("latency after reset", 64'(la8), 64'(lat_exp(336, 8)));

      // 6: skip not a multiple of 8 (truncated for the byte instance)
      load(31'd512, 16'd337, 16'd5);
      run(0, 400, la8, la1);
`ifdef C_SEQ_GEN_FF_SKIP_EN
      skl = 33;
`else
      skl = 26;
`endif
      cmp("latency skip337", 64'(la8), 64'(skl));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
